dcache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and the external memory bus. It serves the load/store port of the pipeline and produces the raw, right-aligned load word plus a one-cycle valid pulse consumed by the write-back stage, which sign-extends it and writes the register file. On a miss or store it raises a stall to the flow controller and runs a word-serial memory transaction.

---
 rtl/dcache_pkg.sv | 46 ++++
 rtl/dcache_data_ram.sv | 30 +++
 rtl/dcache.sv | 163 ++++++++++++++++
 tb/tb_dcache.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared encodings and byte-lane helpers for the direct-mapped write-through data cache.
package dcache_pkg;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_BYTE = 2'b01;
    localparam logic [1:0] W_HALF = 2'b10;
    localparam logic [1:0] W_WORD = 2'b11;

    localparam int LINE_WORDS    = 4;
    localparam int WORD_OFF_BITS = 2;
    localparam int OFFSET_BITS   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REFILL,
        ST_WRITE
    } state_t;

    // Misaligned accesses fall back to the natural boundary by ignoring low address bits.
    function automatic logic [3:0] strobe_of(input logic [1:0] width, input logic [1:0] boff);
        case (width)
            W_BYTE:  return 4'b0001 << boff;
            W_HALF:  return 4'b0011 << {boff[1], 1'b0};
            W_WORD:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] replicate_of(input logic [1:0] width, input logic [31:0] data);
        case (width)
            W_BYTE:  return {4{data[7:0]}};
            W_HALF:  return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] width, input logic [1:0] boff,
                                                 input logic [31:0] word);
        case (width)
            W_BYTE:  return {24'b0, word[{boff, 3'b000} +: 8]};
            W_HALF:  return {16'b0, word[{boff[1], 4'b0000} +: 16]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// Cache data store: byte-writable line array with an asynchronous read port.
module dcache_data_ram
    import dcache_pkg::*;
#(
    parameter int LINES    = 16,
    parameter int IDX_BITS = $clog2(LINES)
) (
    input  logic                clk,
    input  logic [3:0]          we,
    input  logic [IDX_BITS-1:0] windex,
    input  logic [1:0]          wword,
    input  logic [31:0]         wdata,
    input  logic [IDX_BITS-1:0] rindex,
    input  logic [1:0]          rword,
    output logic [31:0]         rdata
);

    logic [31:0] mem [LINES][LINE_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[windex][wword][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[rindex][rword];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a word-serial memory port.
module dcache
    import dcache_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_req_i,
    input  logic        ex_we_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic [1:0]  ex_width_i,
    output logic [31:0] dcache_data_o,
    output logic        dcache_data_valid_o,
    output logic        dcache_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam int IDX_BITS = $clog2(LINES);
    localparam int TAG_BITS = 32 - OFFSET_BITS - IDX_BITS;

    logic [IDX_BITS-1:0] index;
    logic [TAG_BITS-1:0] tag;
    logic [1:0]          word_sel;
    logic                access;
    logic                hit;

    logic [TAG_BITS-1:0] tags [LINES];
    logic [LINES-1:0]    valid;

    state_t              state;
    logic [1:0]          beat;
    logic                wr_hit;
    logic [IDX_BITS-1:0] cur_index;
    logic [TAG_BITS-1:0] cur_tag;
    logic [1:0]          cur_word;

    logic [3:0]          ram_we;
    logic [1:0]          ram_wword;
    logic [31:0]         ram_wdata;
    logic [31:0]         ram_rdata;

    assign index    = ex_addr_i[OFFSET_BITS +: IDX_BITS];
    assign tag      = ex_addr_i[31 -: TAG_BITS];
    assign word_sel = ex_addr_i[3:2];
    assign access   = ex_req_i & (ex_width_i != W_NONE);
    assign hit      = valid[index] & (tags[index] == tag);

    assign dcache_stall_o = ((state == ST_IDLE) & access & (~hit | ex_we_i))
                          | (state == ST_REFILL)
                          | ((state == ST_WRITE) & ~mem_ack_i);

    always_comb begin
        ram_we    = 4'b0000;
        ram_wword = beat;
        ram_wdata = mem_rdata_i;
        if (state == ST_REFILL && mem_ack_i) begin
            ram_we = 4'b1111;
        end else if (state == ST_WRITE && mem_ack_i && wr_hit) begin
            ram_we    = mem_wstrb_o;
            ram_wword = cur_word;
            ram_wdata = mem_wdata_o;
        end
    end

    dcache_data_ram #(
        .LINES    (LINES),
        .IDX_BITS (IDX_BITS)
    ) u_data_ram (
        .clk    (clk),
        .we     (ram_we),
        .windex (cur_index),
        .wword  (ram_wword),
        .wdata  (ram_wdata),
        .rindex (index),
        .rword  (word_sel),
        .rdata  (ram_rdata)
    );

    // Tag written only on the final beat so an aborted refill never looks valid.
    always_ff @(posedge clk) begin
        if (state == ST_REFILL && mem_ack_i && beat == 2'd3) begin
            tags[cur_index] <= cur_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            beat                <= 2'd0;
            wr_hit              <= 1'b0;
            cur_index           <= '0;
            cur_tag             <= '0;
            cur_word            <= 2'd0;
            valid               <= '0;
            mem_req_o           <= 1'b0;
            mem_we_o            <= 1'b0;
            mem_addr_o          <= 32'd0;
            mem_wdata_o         <= 32'd0;
            mem_wstrb_o         <= 4'd0;
            dcache_data_o       <= 32'd0;
            dcache_data_valid_o <= 1'b0;
        end else begin
            dcache_data_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        if (ex_we_i) begin
                            state       <= ST_WRITE;
                            wr_hit      <= hit;
                            cur_index   <= index;
                            cur_word    <= word_sel;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= {ex_addr_i[31:2], 2'b00};
                            mem_wdata_o <= replicate_of(ex_width_i, ex_wdata_i);
                            mem_wstrb_o <= strobe_of(ex_width_i, ex_addr_i[1:0]);
                        end else if (hit) begin
                            dcache_data_o       <= load_extract(ex_width_i, ex_addr_i[1:0], ram_rdata);
                            dcache_data_valid_o <= 1'b1;
                        end else begin
                            state       <= ST_REFILL;
                            beat        <= 2'd0;
                            cur_index   <= index;
                            cur_tag     <= tag;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= {ex_addr_i[31:4], 4'b0000};
                            mem_wstrb_o <= 4'b0000;
                        end
                    end
                end
                ST_REFILL: begin
                    if (mem_ack_i) begin
                        beat            <= beat + 2'd1;
                        mem_addr_o[3:2] <= beat + 2'd1;
                        if (beat == 2'd3) begin
                            valid[cur_index] <= 1'b1;
                            state            <= ST_IDLE;
                            mem_req_o        <= 1'b0;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_ack_i) begin
                        state     <= ST_IDLE;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: loads push expected data, a monitor pops on each valid pulse.
module tb_dcache;
    import dcache_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ex_req_i;
    logic        ex_we_i;
    logic [31:0] ex_addr_i;
    logic [31:0] ex_wdata_i;
    logic [1:0]  ex_width_i;
    logic [31:0] dcache_data_o;
    logic        dcache_data_valid_o;
    logic        dcache_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    dcache #(.LINES(16)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ex_req_i            (ex_req_i),
        .ex_we_i             (ex_we_i),
        .ex_addr_i           (ex_addr_i),
        .ex_wdata_i          (ex_wdata_i),
        .ex_width_i          (ex_width_i),
        .dcache_data_o       (dcache_data_o),
        .dcache_data_valid_o (dcache_data_valid_o),
        .dcache_stall_o      (dcache_stall_o),
        .mem_req_o           (mem_req_o),
        .mem_we_o            (mem_we_o),
        .mem_addr_o          (mem_addr_o),
        .mem_wdata_o         (mem_wdata_o),
        .mem_wstrb_o         (mem_wstrb_o),
        .mem_rdata_i         (mem_rdata_i),
        .mem_ack_i           (mem_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] exp_q [$];
    logic [31:0] rd_log [$];
    logic [31:0] mem [logic [31:0]];
    int          rd_beats = 0;
    int          wr_beats = 0;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;
    logic [3:0]  last_wstrb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Memory model: acks every cycle the request is seen.
    initial begin
        logic [31:0] w;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'd0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req_o) begin
                mem_ack_i = 1'b1;
                if (!mem_we_o) begin
                    mem_rdata_i = memval(mem_addr_o);
                    rd_log.push_back(mem_addr_o);
                    rd_beats++;
                end else begin
                    w = memval(mem_addr_o);
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb_o[b]) w[b*8 +: 8] = mem_wdata_o[b*8 +: 8];
                    mem[mem_addr_o] = w;
                    last_waddr = mem_addr_o;
                    last_wdata = mem_wdata_o;
                    last_wstrb = mem_wstrb_o;
                    wr_beats++;
                end
            end else begin
                mem_ack_i = 1'b0;
            end
        end
    end

    // Monitor: every valid pulse must match the oldest outstanding load.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && dcache_data_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", dcache_data_o, 32'hxxxxxxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("load_data", dcache_data_o, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic access(input logic we, input logic [31:0] addr, input logic [1:0] width,
                          input logic [31:0] wdata, input logic [31:0] exp, output int stalls);
        @(negedge clk);
        ex_req_i   = 1'b1;
        ex_we_i    = we;
        ex_addr_i  = addr;
        ex_width_i = width;
        ex_wdata_i = wdata;
        if (!we) exp_q.push_back(exp);
        stalls = 0;
        #2;
        while (dcache_stall_o && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #2;
        end
        if (stalls >= 200) check("stall_timeout", 32'(stalls), 32'd0);
        @(posedge clk);
        #1;
        ex_req_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #3;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int st;
        int b;
        mem[32'h100] = 32'h11223344;
        mem[32'h104] = 32'h55667788;
        mem[32'h108] = 32'h99AABBCC;
        mem[32'h10C] = 32'hDDEEFF00;
        mem[32'h2000] = 32'hCAFEF00D;

        rst_n = 1'b0; ex_req_i = 1'b0; ex_we_i = 1'b0;
        ex_addr_i = 32'd0; ex_wdata_i = 32'd0; ex_width_i = W_NONE;
        #3;
        check("rst_data", dcache_data_o, 32'd0);
        check("rst_valid", {31'd0, dcache_data_valid_o}, 32'd0);
        check("rst_stall", {31'd0, dcache_stall_o}, 32'd0);
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_we", {31'd0, mem_we_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        check("rst_wstrb", {28'd0, mem_wstrb_o}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #2;
        check("idle_stall", {31'd0, dcache_stall_o}, 32'd0);
        check("idle_req", {31'd0, mem_req_o}, 32'd0);

        // Cold load: four beats then hit
        b = rd_beats; rd_log.delete();
        access(1'b0, 32'h100, W_WORD, 32'd0, 32'h11223344, st);
        check("cold_stalls", 32'(st), 32'd5);
        check("cold_beats", 32'(rd_beats - b), 32'd4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            check("cold_beat_addr", rd_log[i], 32'h100 + 32'(4 * i));
        drain();

        b = rd_beats;
        access(1'b0, 32'h103, W_BYTE, 32'd0, 32'h00000011, st);
        check("byte_hit_stalls", 32'(st), 32'd0);
        access(1'b0, 32'h106, W_HALF, 32'd0, 32'h00005566, st);
        access(1'b0, 32'h10E, W_WORD, 32'd0, 32'hDDEEFF00, st);
        access(1'b0, 32'h10B, W_HALF, 32'd0, 32'h000099AA, st);
        access(1'b0, 32'h109, W_BYTE, 32'd0, 32'h000000BB, st);
        drain();
        check("hit_no_traffic", 32'(rd_beats - b), 32'd0);

        // Back-to-back hits, one per cycle
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            ex_req_i = 1'b1; ex_we_i = 1'b0; ex_width_i = W_WORD;
            ex_addr_i = 32'h100 + 32'(4 * i);
            exp_q.push_back(i == 0 ? 32'h11223344 : (i == 1 ? 32'h55667788 : 32'h99AABBCC));
            #2;
            check("b2b_stall", {31'd0, dcache_stall_o}, 32'd0);
            @(negedge clk);
        end
        ex_req_i = 1'b0;
        drain();

        // Half store hit
        b = wr_beats;
        access(1'b1, 32'h102, W_HALF, 32'h0000BEEF, 32'd0, st);
        check("st_half_stalls", 32'(st), 32'd1);
        check("st_half_beats", 32'(wr_beats - b), 32'd1);
        check("st_half_addr", last_waddr, 32'h100);
        check("st_half_wdata", last_wdata, 32'hBEEFBEEF);
        check("st_half_wstrb", {28'd0, last_wstrb}, 32'h0000000C);
        b = rd_beats;
        access(1'b0, 32'h100, W_WORD, 32'd0, 32'hBEEF3344, st);
        check("after_st_stalls", 32'(st), 32'd0);

        // Byte store hit
        access(1'b1, 32'h109, W_BYTE, 32'h000000AB, 32'd0, st);
        check("st_byte_wdata", last_wdata, 32'hABABABAB);
        check("st_byte_wstrb", {28'd0, last_wstrb}, 32'h00000002);
        access(1'b0, 32'h108, W_WORD, 32'd0, 32'h99AAABCC, st);
        drain();
        check("st_no_refill", 32'(rd_beats - b), 32'd0);

        // Store miss does not allocate
        b = wr_beats;
        access(1'b1, 32'h2000, W_WORD, 32'h12345678, 32'd0, st);
        check("st_miss_beats", 32'(wr_beats - b), 32'd1);
        check("st_miss_wstrb", {28'd0, last_wstrb}, 32'h0000000F);
        b = rd_beats;
        access(1'b0, 32'h2000, W_WORD, 32'd0, 32'h12345678, st);
        check("noalloc_stalls", 32'(st), 32'd5);
        check("noalloc_beats", 32'(rd_beats - b), 32'd4);

        // Eviction by conflicting index
        access(1'b0, 32'h200, W_WORD, 32'd0, memval(32'h200), st);
        check("evict_stalls", 32'(st), 32'd5);
        b = rd_beats;
        access(1'b0, 32'h100, W_WORD, 32'd0, 32'hBEEF3344, st);
        check("reload_stalls", 32'(st), 32'd5);
        check("reload_beats", 32'(rd_beats - b), 32'd4);
        drain();

        // Reset in the middle of a refill
        b = rd_beats;
        @(negedge clk);
        ex_req_i = 1'b1; ex_we_i = 1'b0; ex_addr_i = 32'h3000; ex_width_i = W_WORD;
        for (int k = 0; k < 50 && rd_beats < b + 2; k++) begin
            @(negedge clk);
            #2;
        end
        check("mid_beats_seen", 32'(rd_beats - b), 32'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ex_req_i = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, mem_req_o}, 32'd0);
        check("mid_rst_stall", {31'd0, dcache_stall_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b = rd_beats;
        access(1'b0, 32'h3000, W_WORD, 32'd0, memval(32'h3000), st);
        check("post_rst_stalls", 32'(st), 32'd5);
        check("post_rst_beats", 32'(rd_beats - b), 32'd4);
        b = rd_beats;
        access(1'b0, 32'h100, W_WORD, 32'd0, 32'hBEEF3344, st);
        check("post_rst_100_beats", 32'(rd_beats - b), 32'd4);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
